// File: rtl/snn_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// snn_step_sequencer_if
//   Bundles the control, weight-write and result signals of the SNN step
//   sequencer so the sequencer and its driver connect through one port.
//
//   Signals (direction as seen by the sequencer / slave modport):
//     en            in   global enable, 0 freezes the sequencer
//     step_start    in   request one timestep (taken only when idle)
//     pre_spike     in   INPUTNUM-bit input spike vector
//     wr_en         in   weight write strobe
//     wr_addr       in   weight index i*EXCNUM + j
//     wr_data       in   signed SUM_W-bit weight
//     busy          out  a timestep is in flight
//     sum_valid     out  one-cycle strobe, sum_flat holds a complete result
//     sum_flat      out  EXCNUM packed signed sums, slice j = [j*SUM_W +: SUM_W]
//     step_overrun  out  one-cycle pulse, step_start dropped while busy
//     wr_err        out  one-cycle pulse, write dropped
//
//   wr_addr carries one more code than the table needs, so that an
//   out-of-range index can actually be presented and rejected.
// -----------------------------------------------------------------------------
interface snn_step_sequencer_if #(
  parameter int DW       = 16,
  parameter int INT_DW   = 8,
  parameter int INPUTNUM = 4,
  parameter int EXCNUM   = 2
);
  localparam int SUM_W = DW + INT_DW;
  localparam int NW    = INPUTNUM * EXCNUM;
  localparam int AW    = $clog2(NW + 1);

  logic                      en;
  logic                      step_start;
  logic [INPUTNUM-1:0]       pre_spike;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic signed [SUM_W-1:0]   wr_data;
  logic                      busy;
  logic                      sum_valid;
  logic [EXCNUM*SUM_W-1:0]   sum_flat;
  logic                      step_overrun;
  logic                      wr_err;

  modport master (
    output en, step_start, pre_spike, wr_en, wr_addr, wr_data,
    input  busy, sum_valid, sum_flat, step_overrun, wr_err
  );

  modport slave (
    input  en, step_start, pre_spike, wr_en, wr_addr, wr_data,
    output busy, sum_valid, sum_flat, step_overrun, wr_err
  );
endinterface

// File: rtl/snn_step_sequencer.sv
// -----------------------------------------------------------------------------
// snn_step_sequencer
//   Runs one SNN timestep through a single shared accumulator. On an accepted
//   step request the spike vector is latched, then every (input i, excitatory
//   j) pair is visited one per cycle (j outer, i inner) adding W[i][j] for
//   each spiking input. Each finished column is written to its sum slice; a
//   final PUBLISH cycle raises sum_valid for one cycle and frees the block.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (clears weights, sums and control)
//     bus  snn_step_sequencer_if.slave (control, weight writes, results)
//
//   Build option: define SNN_SEQ_SATURATE_EN to clamp every accumulation to
//   the signed SUM_W range; otherwise adds wrap modulo 2^SUM_W.
// -----------------------------------------------------------------------------
module snn_step_sequencer #(
  parameter int DW       = 16,
  parameter int INT_DW   = 8,
  parameter int INPUTNUM = 4,
  parameter int EXCNUM   = 2
) (
  input logic                  clk,
  input logic                  rst,
  snn_step_sequencer_if.slave  bus
);
  localparam int SUM_W = DW + INT_DW;
  localparam int NW    = INPUTNUM * EXCNUM;
  localparam int AW    = $clog2(NW + 1);
  localparam int PW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW    = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;
  localparam int JW    = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

  state_t                  state_q, state_d;
  logic [INPUTNUM-1:0]     spike_q, spike_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic signed [SUM_W-1:0] w_q   [NW];
  logic signed [SUM_W-1:0] w_d   [NW];
  logic signed [SUM_W-1:0] sum_q [EXCNUM];
  logic signed [SUM_W-1:0] sum_d [EXCNUM];
  logic                    vld_q, vld_d;
  logic                    ovr_q, ovr_d;
  logic                    werr_q, werr_d;
  // Pre-write copy of a weight overwritten on the very edge a step starts;
  // that step must still see the old value.
  logic                    hold_vld_q, hold_vld_d;
  logic [PW-1:0]           hold_addr_q, hold_addr_d;
  logic signed [SUM_W-1:0] hold_val_q, hold_val_d;

  logic                    addr_ok, wr_ok;
  logic [PW-1:0]           pidx;
  logic signed [SUM_W-1:0] w_rd, term, acc_sum;

  function automatic logic signed [SUM_W-1:0] acc_add(
    input logic signed [SUM_W-1:0] a,
    input logic signed [SUM_W-1:0] b
  );
`ifdef SNN_SEQ_SATURATE_EN
    logic [SUM_W:0] s;
    s = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (s[SUM_W] != s[SUM_W-1])
      return s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    return s[SUM_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign addr_ok = bus.wr_addr < AW'(NW);
  assign wr_ok   = bus.en && bus.wr_en && (state_q == IDLE) && addr_ok;
  assign pidx    = PW'(int'(i_q) * EXCNUM + int'(j_q));
  assign w_rd    = (hold_vld_q && (hold_addr_q == pidx)) ? hold_val_q : w_q[pidx];
  assign term    = spike_q[i_q] ? w_rd : '0;
  assign acc_sum = acc_add(acc_q, term);

  always_comb begin
    state_d     = state_q;
    spike_d     = spike_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    w_d         = w_q;
    sum_d       = sum_q;
    vld_d       = 1'b0;
    ovr_d       = 1'b0;
    werr_d      = 1'b0;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_val_d  = hold_val_q;
    if (bus.en) begin
      werr_d = bus.wr_en && ((state_q != IDLE) || !addr_ok);
      ovr_d  = bus.step_start && (state_q != IDLE);
      if (wr_ok) w_d[bus.wr_addr[PW-1:0]] = bus.wr_data;
      case (state_q)
        IDLE: begin
          if (bus.step_start) begin
            spike_d     = bus.pre_spike;
            acc_d       = '0;
            i_d         = '0;
            j_d         = '0;
            state_d     = ACCUM;
            hold_vld_d  = wr_ok;
            hold_addr_d = bus.wr_addr[PW-1:0];
            hold_val_d  = w_q[bus.wr_addr[PW-1:0]];
          end
        end
        ACCUM: begin
          if (i_q == IW'(INPUTNUM - 1)) begin
            // Column j complete: publish its slice and restart the sum.
            sum_d[j_q] = acc_sum;
            acc_d      = '0;
            i_d        = '0;
            if (j_q == JW'(EXCNUM - 1)) begin
              j_d     = '0;
              state_d = PUBLISH;
            end else begin
              j_d = j_q + JW'(1);
            end
          end else begin
            acc_d = acc_sum;
            i_d   = i_q + IW'(1);
          end
        end
        PUBLISH: begin
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      spike_q     <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      w_q         <= '{default: '0};
      sum_q       <= '{default: '0};
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
      werr_q      <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      spike_q     <= spike_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      w_q         <= w_d;
      sum_q       <= sum_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
      werr_q      <= werr_d;
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_val_q  <= hold_val_d;
    end
  end

  // Strobes are silenced for as long as en is low.
  assign bus.busy         = (state_q != IDLE);
  assign bus.sum_valid    = vld_q && bus.en;
  assign bus.step_overrun = ovr_q && bus.en;
  assign bus.wr_err       = werr_q && bus.en;

  for (genvar g = 0; g < EXCNUM; g++) begin : g_flat
    assign bus.sum_flat[g*SUM_W +: SUM_W] = sum_q[g];
  end
endmodule

// File: tb/tb_snn_step_sequencer.sv
module tb_snn_step_sequencer;
  localparam int DW = 16, INT_DW = 8, INPUTNUM = 4, EXCNUM = 2;
  localparam int SUM_W = DW + INT_DW;
  localparam int NW = INPUTNUM * EXCNUM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_step_sequencer_if #(.DW(DW), .INT_DW(INT_DW), .INPUTNUM(INPUTNUM), .EXCNUM(EXCNUM)) bus ();
  snn_step_sequencer #(.DW(DW), .INT_DW(INT_DW), .INPUTNUM(INPUTNUM), .EXCNUM(EXCNUM)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int nvec = 0, nmis = 0;
  int mw[NW];

  typedef struct { logic [3:0] pre; int e0; int e1; } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference adder: exact integer sum, then wrapped or clamped to SUM_W bits.
  function automatic int model_add(input int a, input int b);
    longint s;
    logic signed [SUM_W-1:0] t;
    s = longint'(a) + longint'(b);
`ifdef SNN_SEQ_SATURATE_EN
    if (s > 8388607) s = 8388607;
    if (s < -8388608) s = -8388608;
`endif
    t = s[SUM_W-1:0];
    return int'(t);
  endfunction

  function automatic int model_sum(input logic [3:0] pre, input int j);
    int acc = 0;
    for (int i = 0; i < INPUTNUM; i++)
      if (pre[i]) acc = model_add(acc, mw[i*EXCNUM + j]);
    return acc;
  endfunction

  function automatic int slice(input int j);
    logic signed [SUM_W-1:0] v;
    v = bus.sum_flat[j*SUM_W +: SUM_W];
    return int'(v);
  endfunction

  task automatic write_w(input int addr, input int data);
    logic signed [SUM_W-1:0] d;
    d = data[SUM_W-1:0];
    bus.wr_en = 1'b1; bus.wr_addr = addr[3:0]; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (addr < NW) mw[addr] = int'(d);
  endtask

  task automatic wait_valid(input int start, output int e);
    e = start;
    do begin
      tick();
      e++;
    end while (!bus.sum_valid && e < start + 40);
  endtask

  task automatic run_step(input logic [3:0] pre, input string nm, output int g0, output int g1);
    int e0, e1, lat;
    e0 = model_sum(pre, 0);
    e1 = model_sum(pre, 1);
    bus.pre_spike = pre; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    chk({nm, "_busy"}, bus.busy, 1);
    wait_valid(0, lat);
    chk({nm, "_lat"}, lat, 9);
    g0 = slice(0); g1 = slice(1);
    chk({nm, "_s0"}, g0, e0);
    chk({nm, "_s1"}, g1, e1);
    chk({nm, "_busy_end"}, bus.busy, 0);
    tick();
    chk({nm, "_vld_1cyc"}, bus.sum_valid, 0);
  endtask

  initial begin
    int g0, g1, e, e0, e1, cnt, sat_exp;
    logic [3:0] p;

    tbl[0] = '{4'b1111, 4659557, 6386519};
    tbl[1] = '{4'b0101, 1526656, 4273150};
    tbl[2] = '{4'b0000, 0, 0};
    for (int k = 0; k < NW; k++) mw[k] = 0;

    bus.en = 1'b1; bus.step_start = 1'b0; bus.pre_spike = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.sum_valid, 0);
    chk("rst_flat", bus.sum_flat, 0);
    chk("rst_ovr", bus.step_overrun, 0);
    chk("rst_werr", bus.wr_err, 0);
    rst = 1'b0;
    tick();

    // Reference weights, then table-driven steps.
    write_w(0, 1615585); write_w(1, 592018); write_w(2, 2564138); write_w(3, -153494);
    write_w(4, -88929);  write_w(5, 3681132); write_w(6, 568763); write_w(7, 2266863);
    for (int k = 0; k < 3; k++) begin
      run_step(tbl[k].pre, "tbl", g0, g1);
      chk("tbl_s0_const", g0, tbl[k].e0);
      chk("tbl_s1_const", g1, tbl[k].e1);
    end

    // Back-to-back: new request in the sum_valid cycle.
    bus.pre_spike = 4'b1111; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    wait_valid(0, e);
    chk("b2b_lat_a", e, 9);
    bus.pre_spike = 4'b0101; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    wait_valid(0, e);
    chk("b2b_lat_b", e, 9);
    chk("b2b_s0", slice(0), 1526656);
    chk("b2b_s1", slice(1), 4273150);
    tick();

    // Overrun and write while busy at t0+3.
    bus.pre_spike = 4'b1111; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0; bus.pre_spike = 4'b0000;
    tick(); tick();
    bus.step_start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 24'sd5;
    tick();
    bus.step_start = 1'b0; bus.wr_en = 1'b0;
    chk("ovr_pulse", bus.step_overrun, 1);
    chk("werr_busy_pulse", bus.wr_err, 1);
    tick();
    chk("ovr_clear", bus.step_overrun, 0);
    chk("werr_clear", bus.wr_err, 0);
    wait_valid(4, e);
    chk("ovr_lat", e, 9);
    chk("ovr_s0", slice(0), 4659557);
    chk("ovr_s1", slice(1), 6386519);
    tick();
    run_step(4'b0001, "w_unchanged", g0, g1);
    chk("w_unchanged_const", g0, 1615585);

    // Out-of-range address while idle.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd8; bus.wr_data = 24'sd7;
    tick();
    bus.wr_en = 1'b0;
    chk("werr_addr", bus.wr_err, 1);
    tick();
    chk("werr_addr_clear", bus.wr_err, 0);

    // Enable low for 5 edges from t0+4.
    bus.pre_spike = 4'b1111; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    tick(); tick(); tick();
    bus.en = 1'b0;
    repeat (5) tick();
    chk("en_hold_busy", bus.busy, 1);
    bus.en = 1'b1;
    wait_valid(8, e);
    chk("en_lat", e, 14);
    chk("en_s0", slice(0), 4659557);
    chk("en_s1", slice(1), 6386519);
    tick();

    // Wrap vs saturate.
    write_w(0, 4000000); write_w(2, 4000000); write_w(4, 4000000); write_w(6, 4000000);
`ifdef SNN_SEQ_SATURATE_EN
    sat_exp = 8388607;
`else
    sat_exp = -777216;
`endif
    run_step(4'b1111, "sat", g0, g1);
    chk("sat_const", g0, sat_exp);

    // Randomized weights and spikes against the reference model.
    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(0, 3);
      for (int k = 0; k < cnt; k++) write_w($urandom_range(0, NW-1), int'($urandom));
      p = 4'($urandom_range(0, 15));
      run_step(p, "rand", g0, g1);
    end

    // Reset mid-step.
    bus.pre_spike = 4'b1111; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_flat", bus.sum_flat, 0);
    chk("rstmid_valid", bus.sum_valid, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < NW; k++) mw[k] = 0;
    cnt = 0;
    repeat (15) begin
      tick();
      if (bus.sum_valid) cnt++;
    end
    chk("rstmid_no_valid", cnt, 0);

    // Write and step on the same edge: step sees the old weight.
    write_w(0, 55);
    e0 = model_sum(4'b0001, 0);
    e1 = model_sum(4'b0001, 1);
    bus.pre_spike = 4'b0001; bus.step_start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 24'sd100;
    tick();
    bus.step_start = 1'b0; bus.wr_en = 1'b0;
    mw[0] = 100;
    chk("wrst_werr", bus.wr_err, 0);
    wait_valid(0, e);
    chk("wrst_lat", e, 9);
    chk("wrst_s0_old", slice(0), e0);
    chk("wrst_s0_const", slice(0), 55);
    chk("wrst_s1", slice(1), e1);
    tick();
    run_step(4'b0001, "wrst_new", g0, g1);
    chk("wrst_new_const", g0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
